// File: rtl/decoder_scan_n.sv
// decoder_scan_n: registered N-to-2^N one-hot decoder with a direct
// (handshaken select) mode and a self-sequencing scan mode with
// programmable dwell. Build option: DECODER_BLANK_EN inserts one blank
// cycle after every dwell in scan mode.
module decoder_scan_n #(
  parameter int N       = 3,
  parameter int DWELL   = 4,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       I,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [(1<<N)-1:0]  Y,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  localparam int W     = 1 << N;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [N-1:0]     IDX_MAX    = '1;

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  logic [1:0]       state_p1;
  logic [1:0]       state_nxt;
  logic [W-1:0]     y_p1;
  logic [N-1:0]     idx_p1;
  logic [N-1:0]     idx_inc;
  logic             wrap_p1;
  logic [CNT_W-1:0] cnt_p1;
`ifdef DECODER_BLANK_EN
  logic             blank_p1;
`endif

  function automatic logic [W-1:0] onehot(input logic [N-1:0] sel);
    logic [W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  // Next operating state: en low wins, otherwise mode picks direct or scan.
  always_comb begin
    state_nxt = ST_OFF;
    if (en) begin
      state_nxt = mode ? ST_SCAN : ST_DIRECT;
    end
  end

  assign idx_inc = idx_p1 + N'(1);

  // Stage p1: state, decoded output, scan position and wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= ST_OFF;
      y_p1     <= '0;
      idx_p1   <= '0;
      wrap_p1  <= 1'b0;
      cnt_p1   <= '0;
`ifdef DECODER_BLANK_EN
      blank_p1 <= 1'b0;
`endif
    end else begin
      state_p1 <= state_nxt;
      wrap_p1  <= 1'b0;
      case (state_nxt)
        ST_DIRECT: begin
          cnt_p1 <= '0;
`ifdef DECODER_BLANK_EN
          blank_p1 <= 1'b0;
`endif
          if (state_p1 != ST_DIRECT) begin
            // Fresh entry: stay blank until something is accepted.
            y_p1   <= '0;
            idx_p1 <= '0;
          end else if (in_valid) begin
            y_p1   <= onehot(I);
            idx_p1 <= I;
          end
        end
        ST_SCAN: begin
          if (state_p1 != ST_SCAN) begin
            // Scan always restarts from output 0, never resumes.
            y_p1   <= onehot('0);
            idx_p1 <= '0;
            cnt_p1 <= '0;
`ifdef DECODER_BLANK_EN
            blank_p1 <= 1'b0;
`endif
          end else begin
`ifdef DECODER_BLANK_EN
            if (blank_p1) begin
              blank_p1 <= 1'b0;
              cnt_p1   <= '0;
              idx_p1   <= idx_inc;
              y_p1     <= onehot(idx_inc);
              wrap_p1  <= (idx_p1 == IDX_MAX);
            end else if (cnt_p1 == DWELL_LAST) begin
              // Blank cycle keeps idx on the output just finished.
              blank_p1 <= 1'b1;
              y_p1     <= '0;
            end else begin
              cnt_p1 <= cnt_p1 + CNT_W'(1);
            end
`else
            if (cnt_p1 == DWELL_LAST) begin
              cnt_p1  <= '0;
              idx_p1  <= idx_inc;
              y_p1    <= onehot(idx_inc);
              wrap_p1 <= (idx_p1 == IDX_MAX);
            end else begin
              cnt_p1 <= cnt_p1 + CNT_W'(1);
            end
`endif
          end
        end
        default: begin
          y_p1   <= '0;
          idx_p1 <= '0;
          cnt_p1 <= '0;
`ifdef DECODER_BLANK_EN
          blank_p1 <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign in_ready = (state_p1 == ST_DIRECT);
  assign Y        = ACT_LOW ? ~y_p1 : y_p1;
  assign idx      = idx_p1;
  assign wrap     = wrap_p1;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed testbench for decoder_scan_n: reset, direct decode, scan
// sequencing with wrap, mid-scan abort, enable drop and active-low output.
module tb_decoder_scan_n;

`ifdef DECODER_BLANK_EN
  localparam int BLANK = 1;
`else
  localparam int BLANK = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en, mode, in_valid;
  logic [2:0] sel;
  logic       in_ready;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;

  logic       en2, mode2, in_valid2;
  logic [1:0] sel2;
  logic       in_ready2;
  logic [3:0] y2;
  logic [1:0] idx2;
  logic       wrap2;

  int n_vec = 0;
  int n_err = 0;

  decoder_scan_n #(.N(3), .DWELL(4), .ACT_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .I(sel),
    .in_valid(in_valid), .in_ready(in_ready), .Y(y), .idx(idx), .wrap(wrap)
  );

  decoder_scan_n #(.N(2), .DWELL(2), .ACT_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .en(en2), .mode(mode2), .I(sel2),
    .in_valid(in_valid2), .in_ready(in_ready2), .Y(y2), .idx(idx2), .wrap(wrap2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected active-high output k cycles after scan entry.
  function automatic logic [7:0] scan_y(input int k, input int dwell, input int nsl);
    int per, pos, slot;
    per  = dwell + BLANK;
    pos  = k % per;
    slot = (k / per) % nsl;
    if (pos == dwell) return 8'h00;
    return 8'(1 << slot);
  endfunction

  function automatic logic [2:0] scan_idx(input int k, input int dwell, input int nsl);
    return 3'((k / (dwell + BLANK)) % nsl);
  endfunction

  function automatic logic scan_wrap(input int k, input int dwell, input int nsl);
    return (k > 0) && (k % ((dwell + BLANK) * nsl) == 0);
  endfunction

  initial begin
    logic [3:0] e4;
    rst = 1'b1; en = 1'b1; mode = 1'b1; in_valid = 1'b0; sel = 3'd0;
    en2 = 1'b0; mode2 = 1'b0; in_valid2 = 1'b0; sel2 = 2'd0;

    // Reset held two cycles with scan requested
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_y", 32'(y), 32'h00);
      check("rst_idx", 32'(idx), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
    end
    check("rst_y2", 32'(y2), 32'hF);
    rst = 1'b0;

    // Scan from entry: k = 0 is the first cycle after reset release
    for (int k = 0; k <= 70; k++) begin
      tick();
      check("scan_y", 32'(y), 32'(scan_y(k, 4, 8)));
      check("scan_idx", 32'(idx), 32'(scan_idx(k, 4, 8)));
      check("scan_wrap", 32'(wrap), 32'(scan_wrap(k, 4, 8)));
      check("scan_ready", 32'(in_ready), 32'd0);
    end

    // Drop enable, then re-enter scan and stop on output 5
    en = 1'b0;
    tick();
    check("off_y", 32'(y), 32'h00);
    check("off_idx", 32'(idx), 32'd0);
    en = 1'b1;
    for (int k = 0; k <= 5 * (4 + BLANK) + 1; k++) begin
      tick();
      check("scan2_y", 32'(y), 32'(scan_y(k, 4, 8)));
    end
    check("abort_pre_idx", 32'(idx), 32'd5);
    mode = 1'b0;
    tick();
    check("abort_y", 32'(y), 32'h00);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_idx", 32'(idx), 32'd0);
    check("abort_wrap", 32'(wrap), 32'd0);

    // Direct decode with in_valid held and I stepping every cycle
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      tick();
      check("dir_y", 32'(y), 32'(1 << i));
      check("dir_idx", 32'(idx), 32'(i));
      check("dir_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0; sel = 3'd3;
    tick();
    check("dir_hold_y", 32'(y), 32'h80);
    check("dir_hold_idx", 32'(idx), 32'd7);

    // Back to scan restarts at output 0 without a wrap
    mode = 1'b1;
    tick();
    check("rescan_y", 32'(y), 32'h01);
    check("rescan_idx", 32'(idx), 32'd0);
    check("rescan_wrap", 32'(wrap), 32'd0);
    tick();
    check("rescan_wrap1", 32'(wrap), 32'd0);

    // Input presented as enable drops is discarded
    mode = 1'b0;
    tick();
    check("dir_entry_y", 32'(y), 32'h00);
    in_valid = 1'b1; sel = 3'd6; en = 1'b0;
    tick();
    check("en_drop_y", 32'(y), 32'h00);
    check("en_drop_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Active-low, N = 2
    en2 = 1'b1; mode2 = 1'b0;
    tick();
    check("al_entry_y", 32'(y2), 32'hF);
    check("al_ready", 32'(in_ready2), 32'd1);
    in_valid2 = 1'b1; sel2 = 2'd2;
    tick();
    check("al_dir_y", 32'(y2), 32'hB);
    check("al_dir_idx", 32'(idx2), 32'd2);
    in_valid2 = 1'b0; en2 = 1'b0;
    tick();
    check("al_off_y", 32'(y2), 32'hF);
    check("al_off_ready", 32'(in_ready2), 32'd0);

    // Active-low scan, N = 2, DWELL = 2 (blank cycles when built with them)
    en2 = 1'b1; mode2 = 1'b1;
    for (int k = 0; k < 26; k++) begin
      tick();
      e4 = ~4'(scan_y(k, 2, 4));
      check("al_scan_y", 32'(y2), 32'(e4));
      check("al_scan_idx", 32'(idx2), 32'(2'(scan_idx(k, 2, 4))));
      check("al_scan_wrap", 32'(wrap2), 32'(scan_wrap(k, 2, 4)));
    end

    // Reset mid-operation overrides enable and mode
    rst = 1'b1;
    tick();
    check("rst_mid_y2", 32'(y2), 32'hF);
    check("rst_mid_idx2", 32'(idx2), 32'd0);
    check("rst_mid_wrap2", 32'(wrap2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
